// File: rtl/multdiv_seq_pkg.sv
// rtl/multdiv_seq_pkg.sv - shared widths, state encoding and helpers for the multiply/divide unit
package multdiv_defs;

  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH;
  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/multdiv_seq_if.sv
// rtl/multdiv_seq_if.sv - operand/start/result bundle between execute stage and multiply/divide unit
interface multdiv_seq_if;
  import multdiv_defs::*;

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/csa_32bit.sv
// rtl/csa_32bit.sv - 32-bit carry-select adder with carry in/out
module csa_32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [16:0] w_lo;
  logic [16:0] w_hi0;
  logic [16:0] w_hi1;

  assign w_lo  = {1'b0, i_a[15:0]} + {1'b0, i_b[15:0]} + {16'd0, i_cin};
  assign w_hi0 = {1'b0, i_a[31:16]} + {1'b0, i_b[31:16]};
  assign w_hi1 = {1'b0, i_a[31:16]} + {1'b0, i_b[31:16]} + 17'd1;

  assign o_sum[15:0]           = w_lo[15:0];
  assign {o_cout, o_sum[31:16]} = w_lo[16] ? w_hi1 : w_hi0;

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// rtl/multdiv_seq_ctrl.sv - sequencing FSM and iteration counter for the multiply/divide unit
module multdiv_ctrl
  import multdiv_defs::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_start_mul,
  input  logic i_start_div,
  output logic o_busy,
  output logic o_done
);

  state_t     r_state;
  logic [5:0] r_cnt;

  // A new start always wins, so an operation in flight is dropped without a DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else if (i_start_mul) begin
      r_state <= S_MUL;
      r_cnt   <= 6'd0;
    end else if (i_start_div) begin
      r_state <= S_DIV;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        S_MUL, S_DIV: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == LAST_CNT) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state == S_MUL) || (r_state == S_DIV);
  assign o_done = (r_state == S_DONE);

endmodule

// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - multi-cycle signed 32-bit shift-add multiplier / restoring divider
module multdiv_seq
  import multdiv_defs::*;
(
  input  logic          clock,
  input  logic          reset,
  multdiv_seq_if.slave  bus
);

  logic             w_start;
  logic             w_start_div;
  logic             w_busy;
  logic             w_done;

  logic             r_is_mul;
  logic             r_neg;
  logic             r_divz;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;

  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_lo_next;

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quot_s;
  logic               w_mul_exc;
  logic [WIDTH-1:0]   w_fin_res;
  logic               w_fin_exc;

  assign w_start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign w_start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;

  multdiv_ctrl u_ctrl (
    .clock       (clock),
    .reset       (reset),
    .i_start_mul (bus.ctrl_MULT),
    .i_start_div (w_start_div),
    .o_busy      (w_busy),
    .o_done      (w_done)
  );

  // MUL: acc += multiplicand when lo[0]; DIV: trial subtract of divisor from shifted remainder.
  assign w_add_a = r_is_mul ? r_acc : {r_acc[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_add_b = r_is_mul ? (r_lo[0] ? r_opb : '0) : ~r_opb;

  csa_32bit u_add (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (~r_is_mul),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Shifted remainder is 33 bits; its top bit is acc[31], so no borrow if that or the carry is set.
  assign w_no_borrow = r_acc[WIDTH-1] | w_cout;

  always_comb begin
    w_acc_next = r_acc;
    w_lo_next  = r_lo;
    if (r_is_mul) begin
      w_acc_next = {w_cout, w_sum[WIDTH-1:1]};
      w_lo_next  = {w_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_acc_next = w_no_borrow ? w_sum : w_add_a;
      w_lo_next  = {r_lo[WIDTH-2:0], w_no_borrow};
    end
  end

  assign w_prod    = {r_acc, r_lo};
  assign w_prod_s  = r_neg ? (~w_prod + 64'd1) : w_prod;
  assign w_quot_s  = r_neg ? (~r_lo + WIDTH'(1)) : r_lo;
  assign w_mul_exc = ~((&w_prod_s[2*WIDTH-1:WIDTH-1]) | ~(|w_prod_s[2*WIDTH-1:WIDTH-1]));

  // A positive quotient with bit 31 set can only come from 0x80000000 / -1.
  assign w_fin_res = r_is_mul ? w_prod_s[WIDTH-1:0] : (r_divz ? '0 : w_quot_s);
  assign w_fin_exc = r_is_mul ? w_mul_exc : (r_divz | (~r_neg & r_lo[WIDTH-1]));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_is_mul <= 1'b0;
      r_neg    <= 1'b0;
      r_divz   <= 1'b0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= w_done;
      if (w_done) begin
        r_result <= w_fin_res;
        r_exc    <= w_fin_exc;
      end
      if (w_start) begin
        r_is_mul <= bus.ctrl_MULT;
        r_neg    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        r_divz   <= (bus.data_operandB == '0);
        r_opb    <= magnitude(bus.data_operandB);
        r_lo     <= magnitude(bus.data_operandA);
        r_acc    <= '0;
      end else if (w_busy) begin
        r_acc <= w_acc_next;
        r_lo  <= w_lo_next;
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_seq.sv
// tb/tb_multdiv_seq.sv - directed self-checking bench for multdiv_seq
module tb_multdiv_seq;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  multdiv_seq_if bus();

  multdiv_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; the following rising edge is E0. Operands are scrambled afterwards.
  task automatic launch(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = ~a ^ 32'h5A5A_1234;
    bus.data_operandB = b + 32'h0001_0003;
  endtask

  task automatic watch(input string tag, input logic [31:0] exp_res, input logic exp_exc);
    int          first = 0;
    int          cnt   = 0;
    logic [31:0] res_at = 32'hDEAD_BEEF;
    logic        exc_at = 1'bx;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY === 1'b1) begin
        cnt++;
        if (first == 0) begin
          first  = k;
          res_at = bus.data_result;
          exc_at = bus.data_exception;
        end
      end
    end
    check({tag, ".rdy_at"},  first,  32'd33);
    check({tag, ".rdy_cnt"}, cnt,    32'd1);
    check({tag, ".result"},  res_at, exp_res);
    check({tag, ".exc"},     {31'd0, exc_at}, {31'd0, exp_exc});
  endtask

  task automatic count_rdy(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY !== 1'b0) cnt++;
    end
  endtask

  initial begin
    int held_bad;
    int n;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    check("reset.result", bus.data_result, 32'd0);
    check("reset.exc",    {31'd0, bus.data_exception}, 32'd0);
    check("reset.rdy",    {31'd0, bus.data_resultRDY}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    launch(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    watch("mul_7x-6", 32'hFFFF_FFD6, 1'b0);
    held_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (bus.data_result !== 32'hFFFF_FFD6 || bus.data_resultRDY !== 1'b0 ||
          bus.data_exception !== 1'b0) held_bad++;
    end
    check("mul_7x-6.hold", held_bad, 32'd0);

    launch(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    watch("mul_ovf", 32'h0000_0000, 1'b1);
    launch(1'b1, 1'b0, 32'h8000_0000, 32'd1);
    watch("mul_min_x1", 32'h8000_0000, 1'b0);
    launch(1'b1, 1'b0, 32'hFFFF_8000, 32'h0001_0000);
    watch("mul_neg_2p31", 32'h8000_0000, 1'b0);
    launch(1'b1, 1'b0, 32'h0000_8000, 32'h0001_0000);
    watch("mul_pos_2p31", 32'h8000_0000, 1'b1);

    launch(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    watch("div_-7/2", 32'hFFFF_FFFD, 1'b0);
    launch(1'b0, 1'b1, 32'd100, 32'd7);
    watch("div_100/7", 32'd14, 1'b0);
    launch(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    watch("div_-100/-7", 32'd14, 1'b0);
    launch(1'b0, 1'b1, 32'd5, 32'd0);
    watch("div_by0", 32'd0, 1'b1);
    launch(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    watch("div_ovf", 32'h8000_0000, 1'b1);

    launch(1'b1, 1'b0, 32'd3, 32'd4);
    count_rdy(9, n);
    check("abort.early_rdy", n, 32'd0);
    launch(1'b0, 1'b1, 32'd20, 32'd4);
    watch("abort_div", 32'd5, 1'b0);

    launch(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (14) @(posedge clock);
    #3;
    check("rst.pre_result", bus.data_result, 32'd5);
    reset = 1'b0;
    #1;
    check("rst.result", bus.data_result, 32'd0);
    check("rst.exc",    {31'd0, bus.data_exception}, 32'd0);
    check("rst.rdy",    {31'd0, bus.data_resultRDY}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    count_rdy(40, n);
    check("rst.no_rdy", n, 32'd0);

    launch(1'b1, 1'b1, 32'd3, 32'd5);
    watch("both_mul_wins", 32'd15, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
